// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential unsigned shift-and-add multiplier.
// One 2N-bit adder is shared across N iterations. The request side is a
// start/busy/done handshake, and the result register drives product.
// Optional build macro: SEQ_MULT_EARLY_TERM_EN. When it is defined, RUN
// stops as soon as no set multiplier bits remain, so the latency depends
// on b.

// Combinational ripple adder. This is the only arithmetic resource.
module adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);
  // Full-width add; the carry out is the extra top bit.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b};
  end
endmodule

// state | meaning
// IDLE  | waiting for start; operands sampled on the accept edge
// RUN   | one shift-and-add iteration per clock
// DONE  | product valid, done pulses for one cycle
module seq_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int W  = 2 * N;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [W-1:0]   acc;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   sum;
  logic           cout_unused;

  // The carry cannot be set: an N x N product always fits in 2N bits.
  adder #(.W(W)) u_adder (
    .a    (acc),
    .b    (mcand),
    .sum  (sum),
    .cout (cout_unused)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef SEQ_MULT_EARLY_TERM_EN
          if (b == '0) state_nxt = DONE;
          else         state_nxt = RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN: begin
`ifdef SEQ_MULT_EARLY_TERM_EN
        // Stop once the shifted multiplier has no set bits left.
        if (cnt == LAST || mplier[N-1:1] == '0) state_nxt = DONE;
`else
        if (cnt == LAST) state_nxt = DONE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, then shift and conditionally add once per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == IDLE && start) begin
      mcand  <= {{N{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      if (mplier[0]) acc <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // Outputs come from registered state only.
  always_comb begin
    busy    = (state == RUN);
    done    = (state == DONE);
    product = acc;
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (N=8), using a timeline model of the handshake.
module tb_seq_multiplier;
  localparam int N = 8;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] product;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit           m_run = 0, m_done = 0, chk_en = 0;
  int           m_iter = 0, m_lat = 0;
  int           m_accepts = 0, m_completions = 0, dut_pulses = 0;
  logic [N-1:0] m_a = '0, m_b = '0;
  logic [W-1:0] m_prod = '0;

  function automatic int latency(input logic [N-1:0] bv);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int msb = 0;
    for (int i = 0; i < N; i++) if (bv[i]) msb = i + 1;
    return msb;
`else
    return N;
`endif
  endfunction

  // a times the low i bits of b: the partial product after i iterations.
  function automatic logic [W-1:0] partial(input logic [N-1:0] av, input logic [N-1:0] bv, input int i);
    logic [W-1:0] mask;
    mask = (W'(1) << i) - W'(1);
    return W'(av) * (W'(bv) & mask);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_done = 0; m_iter = 0; m_prod = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_run) begin
      m_iter++;
      m_prod = partial(m_a, m_b, m_iter);
      if (m_iter == m_lat) begin
        m_run = 0; m_done = 1; m_completions++;
      end
    end else if (start) begin
      m_a = a; m_b = b; m_prod = '0; m_iter = 0; m_lat = latency(b);
      m_accepts++;
      if (m_lat == 0) begin m_done = 1; m_completions++; end
      else m_run = 1;
    end
  end

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", W'(busy), W'(m_run));
      check("done", W'(done), W'(m_done));
      check("product", product, m_prod);
      if (done) dut_pulses++;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_done(input string nm, output int lat);
    int cyc = 0;
    lat = 0;
    while (!done && cyc < 40) begin
      if (busy) lat++;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done within %0d cycles", nm, cyc);
    end
  endtask

  task automatic op(input logic [N-1:0] av, input logic [N-1:0] bv,
                    input logic [W-1:0] exp, input int exp_lat, input string nm);
    int lat;
    @(posedge clk); #1;
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = N'($urandom); b = N'($urandom);
    wait_done(nm, lat);
    check({nm, " result"}, product, exp);
    check({nm, " latency"}, W'(lat), W'(exp_lat));
    @(posedge clk); #1;
    check({nm, " held"}, product, exp);
    check({nm, " single pulse"}, W'(done), W'(0));
  endtask

  initial begin
    int lat;
    int base;
    int cyc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    check("reset product", product, W'(0));
    chk_en = 1;
    @(posedge clk); #1;
    rst = 1'b0;

    op(8'd15, 8'd15, 16'd225, latency(8'd15), "15x15");
    op(8'd9, 8'd0, 16'd0, latency(8'd0), "9x0");
    op(8'd0, 8'd13, 16'd0, latency(8'd13), "0x13");
    op(8'd255, 8'd255, 16'd65025, latency(8'd255), "255x255");
    op(8'd200, 8'd1, 16'd200, latency(8'd1), "200x1");
    op(8'd37, 8'd6, 16'd222, latency(8'd6), "37x6");
`ifndef SEQ_MULT_EARLY_TERM_EN
    op(8'd100, 8'd128, 16'd12800, 8, "100x128");
`endif

    // start held high through RUN and DONE with different operands
    @(posedge clk); #1;
    start = 1'b1; a = 8'd3; b = 8'd5;
    @(posedge clk); #1;
    a = 8'd7; b = 8'd7;
    wait_done("hold first", lat);
    check("hold first result", product, 16'd15);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("hold second", lat);
    check("hold second result", product, 16'd49);
    @(posedge clk); #1;

    // reset during the second RUN cycle
    start = 1'b1; a = 8'd12; b = 8'd11;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy", W'(busy), W'(0));
    check("abort done", W'(done), W'(0));
    check("abort product", product, W'(0));
    rst = 1'b0;
    op(8'd12, 8'd11, 16'd132, latency(8'd11), "12x11 after reset");

    // random sweep
    base = m_accepts;
    cyc = 0;
    while (m_accepts - base < 1000 && cyc < 40000) begin
      @(posedge clk); #1;
      start = ($urandom_range(3) != 0);
      a = N'($urandom);
      b = N'($urandom);
      cyc++;
    end
    start = 1'b0;
    repeat (N + 3) @(posedge clk);
    #1;
    check("sweep accepts", W'(m_accepts - base >= 1000), W'(1));
    check("done pulse count", W'(dut_pulses), W'(m_completions));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
